// File: rtl/camera_ctrl_pkg.sv
// camera_ctrl_pkg: shared types and constants for the camera bring-up
// sequencer and its init-script table.
package camera_ctrl_pkg;

    localparam int ENTRY_W     = 24;
    localparam int TABLE_DEPTH = 64;
    localparam int IDX_W       = $clog2(TABLE_DEPTH);

    // Reserved register addresses that turn a table entry into a command
    localparam logic [15:0] ADDR_DELAY = 16'hFFFF;
    localparam logic [15:0] ADDR_END   = 16'hFFFE;

    typedef enum logic [2:0] {
        IDLE,
        PWR_OFF,
        BOOT,
        FETCH,
        WRITE,
        DELAY,
        STREAM,
        ERROR
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } entry_t;

    // Status pins that depend only on the state being entered
    typedef struct packed {
        logic gpio;
        logic busy;
        logic done;
        logic error;
        logic rx_en;
    } status_t;

    function automatic status_t state_status(state_t s);
        status_t st;
        st = '0;
        case (s)
            IDLE:    st = '0;
            PWR_OFF: st.busy = 1'b1;
            BOOT, FETCH, WRITE, DELAY: begin
                st.gpio = 1'b1;
                st.busy = 1'b1;
            end
            STREAM: begin
                st.gpio  = 1'b1;
                st.done  = 1'b1;
                st.rx_en = 1'b1;
            end
            ERROR:   st.error = 1'b1;
            default: st = '0;
        endcase
        return st;
    endfunction

    function automatic int max_int(int a, int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/camera_init_rom.sv
// camera_init_rom: board init script for the camera sensor. One 24-bit
// {addr[15:0], data[7:0]} entry per index, registered read with one cycle
// of latency. Unlisted slots read as the end-of-table marker.
module camera_init_rom
    import camera_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic [IDX_W-1:0]   idx,
    output logic [ENTRY_W-1:0] entry
);

    function automatic entry_t script_entry(logic [IDX_W-1:0] i);
        case (i)
            IDX_W'(0): return '{addr: 16'h3008, data: 8'h82};
            IDX_W'(1): return '{addr: ADDR_DELAY, data: 8'h03};
            IDX_W'(2): return '{addr: 16'h0100, data: 8'h01};
            IDX_W'(3): return '{addr: ADDR_END, data: 8'h00};
            default:   return '{addr: ADDR_END, data: 8'h00};
        endcase
    endfunction

    // Registered table read; the sequencer waits one cycle for it
    // NOTE: the table is a constant ROM, so its output register carries no
    // reset; the sequencer never consumes it before a fresh read.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for every clocked register.
        entry <= script_entry(idx);
    end

endmodule

// File: rtl/camera_init_seq.sv
// camera_init_seq: camera power-up and register-init sequencer. Holds the
// camera off, powers it, waits for boot, walks the init script issuing
// register writes (with retries and timed delays) and then enables the
// receive path. Optional macro CAM_WATCHDOG_EN adds a frame watchdog that
// restarts the sequence when vsync stops while streaming.
module camera_init_seq
    import camera_ctrl_pkg::*;
#(
    parameter int PWR_OFF_CYC  = 200000,
    parameter int BOOT_CYC     = 2000000,
    parameter int DLY_UNIT_CYC = 200000,
    parameter int MAX_RETRY    = 3,
    parameter int WDT_CYC      = 40000000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    output logic             o_camera_gpio,
    output logic             o_wr_req,
    output logic [15:0]      o_wr_addr,
    output logic [7:0]       o_wr_data,
    input  logic             i_wr_ack,
    input  logic             i_wr_err,
    output logic             o_rx_enable,
    input  logic             i_frame_vsync,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [IDX_W-1:0] o_entry_idx
);

    // One shared timer covers power-off, boot and table delays
    localparam int DLY_MAX = 255 * DLY_UNIT_CYC;
    localparam int CNT_MAX = max_int(max_int(PWR_OFF_CYC, BOOT_CYC), DLY_MAX);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t               state;
    status_t              status;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     dly_last;
    logic [IDX_W-1:0]     idx;
    logic [RETRY_W-1:0]   retry_cnt;
    logic                 fetch_vld;
    logic                 wr_req;
    logic [15:0]          wr_addr;
    logic [7:0]           wr_data;
    logic [ENTRY_W-1:0]   rom_q;
    entry_t               ent;
    logic                 wdt_expired;

    assign ent = entry_t'(rom_q);

    camera_init_rom u_rom (
        .clk   (i_clk),
        .idx   (idx),
        .entry (rom_q)
    );

`ifdef CAM_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYC + 1);

    logic             vsync_q;
    logic             vsync_rise;
    logic [WDT_W-1:0] wdt_cnt;

    assign vsync_rise  = i_frame_vsync & ~vsync_q;
    assign wdt_expired = (state == STREAM) && !vsync_rise &&
                         (wdt_cnt == WDT_W'(WDT_CYC - 1));

    // Count streaming cycles since the last vsync rising edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vsync_q <= 1'b0;
            wdt_cnt <= '0;
        end else begin
            vsync_q <= i_frame_vsync;
            if (state != STREAM || vsync_rise || i_start || wdt_expired)
                wdt_cnt <= '0;
            else
                wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end
`else
    // Streaming persists; vsync is deliberately left unconnected
    logic unused_vsync;
    assign unused_vsync = i_frame_vsync;
    assign wdt_expired  = 1'b0;
`endif

    // Sequencer FSM; status pins are registered alongside the state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            status    <= '0;
            cnt       <= '0;
            dly_last  <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            fetch_vld <= 1'b0;
            wr_req    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else if (i_start || wdt_expired) begin
            state     <= PWR_OFF;
            status    <= state_status(PWR_OFF);
            cnt       <= '0;
            idx       <= '0;
            retry_cnt <= '0;
            fetch_vld <= 1'b0;
            wr_req    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            case (state)
                IDLE: ;
                PWR_OFF: begin
                    if (cnt == CNT_W'(PWR_OFF_CYC - 1)) begin
                        cnt    <= '0;
                        state  <= BOOT;
                        status <= state_status(BOOT);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BOOT: begin
                    if (cnt == CNT_W'(BOOT_CYC - 1)) begin
                        cnt       <= '0;
                        fetch_vld <= 1'b0;
                        state     <= FETCH;
                        status    <= state_status(FETCH);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                FETCH: begin
                    // First cycle presents the index, second decodes the entry
                    if (!fetch_vld) begin
                        fetch_vld <= 1'b1;
                    end else begin
                        fetch_vld <= 1'b0;
                        if (ent.addr == ADDR_DELAY) begin
                            cnt      <= '0;
                            dly_last <= (ent.data == 8'd0) ? '0 :
                                        CNT_W'(int'(ent.data) * DLY_UNIT_CYC - 1);
                            state    <= DELAY;
                            status   <= state_status(DELAY);
                        end else if (ent.addr == ADDR_END) begin
                            state  <= STREAM;
                            status <= state_status(STREAM);
                        end else begin
                            wr_addr <= ent.addr;
                            wr_data <= ent.data;
                            wr_req  <= 1'b1;
                            state   <= WRITE;
                            status  <= state_status(WRITE);
                        end
                    end
                end
                WRITE: begin
                    if (i_wr_ack) begin
                        wr_req <= 1'b0;
                        if (!i_wr_err) begin
                            retry_cnt <= '0;
                            if (idx == IDX_W'(TABLE_DEPTH - 1)) begin
                                state  <= ERROR;
                                status <= state_status(ERROR);
                            end else begin
                                idx    <= idx + IDX_W'(1);
                                state  <= FETCH;
                                status <= state_status(FETCH);
                            end
                        end else if (retry_cnt == RETRY_W'(MAX_RETRY)) begin
                            state  <= ERROR;
                            status <= state_status(ERROR);
                        end else begin
                            // Same index, so FETCH reissues the same entry
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            state     <= FETCH;
                            status    <= state_status(FETCH);
                        end
                    end
                end
                DELAY: begin
                    if (cnt == dly_last) begin
                        cnt <= '0;
                        if (idx == IDX_W'(TABLE_DEPTH - 1)) begin
                            state  <= ERROR;
                            status <= state_status(ERROR);
                        end else begin
                            idx    <= idx + IDX_W'(1);
                            state  <= FETCH;
                            status <= state_status(FETCH);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STREAM: ;
                ERROR: ;
                default: begin
                    state  <= IDLE;
                    status <= '0;
                end
            endcase
        end
    end

    assign o_camera_gpio = status.gpio;
    assign o_busy        = status.busy;
    assign o_done        = status.done;
    assign o_error       = status.error;
    assign o_rx_enable   = status.rx_en;
    assign o_wr_req      = wr_req;
    assign o_wr_addr     = wr_addr;
    assign o_wr_data     = wr_data;
    assign o_entry_idx   = idx;

endmodule

// File: tb/tb_camera_init_seq.sv
// tb_camera_init_seq: self-checking bench for camera_init_seq. A table-walk
// model predicts the write stream, gaps between requests and final status;
// an inline responder acks requests with randomized latency and errors.
module tb_camera_init_seq;

    localparam int PWR_OFF_CYC  = 4;
    localparam int BOOT_CYC     = 8;
    localparam int DLY_UNIT_CYC = 2;
    localparam int MAX_RETRY    = 3;
    localparam int WDT_CYC      = 50;
    // Each table entry costs a ROM read cycle plus a decode cycle
    localparam int FETCH_CYC    = 2;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_wr_ack = 1'b0;
    logic        i_wr_err = 1'b0;
    logic        i_frame_vsync = 1'b0;
    logic        o_camera_gpio, o_wr_req, o_rx_enable, o_busy, o_done, o_error;
    logic [15:0] o_wr_addr;
    logic [7:0]  o_wr_data;
    logic [5:0]  o_entry_idx;

    always #5 clk = ~clk;

    camera_init_seq #(
        .PWR_OFF_CYC  (PWR_OFF_CYC),
        .BOOT_CYC     (BOOT_CYC),
        .DLY_UNIT_CYC (DLY_UNIT_CYC),
        .MAX_RETRY    (MAX_RETRY),
        .WDT_CYC      (WDT_CYC)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .o_camera_gpio (o_camera_gpio),
        .o_wr_req      (o_wr_req),
        .o_wr_addr     (o_wr_addr),
        .o_wr_data     (o_wr_data),
        .i_wr_ack      (i_wr_ack),
        .i_wr_err      (i_wr_err),
        .o_rx_enable   (o_rx_enable),
        .i_frame_vsync (i_frame_vsync),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_entry_idx   (o_entry_idx)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
        int          gap;
    } wr_t;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] tbl_addr [4];
    logic [7:0]  tbl_data [4];

    wr_t exp_q[$];
    wr_t got_q[$];
    bit  err_plan[$];
    bit  exp_error;
    int  exp_idx;
    int  exp_done_gap;

    bit          resp_on = 1'b0;
    bit          resp_busy = 1'b0;
    int          resp_lat = 2;
    int          resp_wait = 0;
    bit          prev_req = 1'b0;
    int          low_run = 0;
    int          unstable = 0;
    logic [23:0] cur_wr = '0;
    bit          gpio_meas = 1'b0;
    int          gpio_low = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample at the falling edge and run the write responder
    task automatic step();
        @(negedge clk);
        i_start  = 1'b0;
        i_wr_ack = 1'b0;
        i_wr_err = 1'b0;
        if (gpio_meas) begin
            if (!o_camera_gpio) gpio_low++;
            else gpio_meas = 1'b0;
        end
        if (o_wr_req) begin
            if (!prev_req) got_q.push_back('{o_wr_addr, o_wr_data, low_run});
            else if ({o_wr_addr, o_wr_data} != cur_wr) unstable++;
            cur_wr  = {o_wr_addr, o_wr_data};
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_req = o_wr_req;
        if (!o_wr_req) begin
            resp_busy = 1'b0;
        end else if (resp_on) begin
            if (!resp_busy) begin
                resp_busy = 1'b1;
                resp_wait = resp_lat;
            end
            if (resp_wait == 0) begin
                i_wr_ack  = 1'b1;
                i_wr_err  = (err_plan.size() > 0) ? err_plan.pop_front() : 1'b0;
                resp_busy = 1'b0;
            end else begin
                resp_wait--;
            end
        end
    endtask

    task automatic do_start();
        i_start   = 1'b1;
        low_run   = 0;
        gpio_meas = 1'b1;
        gpio_low  = 0;
        step();
    endtask

    // Walk the script: expected writes, idle gaps before each request, outcome
    task automatic build_model(input int ne0, input int ne1);
        int ne[2];
        int w;
        int pending;
        int fails;
        int issues;
        ne[0] = ne0;
        ne[1] = ne1;
        exp_q.delete();
        err_plan.delete();
        exp_error = 1'b0;
        exp_idx   = 0;
        pending   = PWR_OFF_CYC + BOOT_CYC;
        w         = 0;
        for (int i = 0; i < 4; i++) begin
            if (tbl_addr[i] == 16'hFFFF) begin
                pending += FETCH_CYC + ((tbl_data[i] == 0) ? 1 : int'(tbl_data[i]) * DLY_UNIT_CYC);
            end else if (tbl_addr[i] == 16'hFFFE) begin
                pending += FETCH_CYC;
                exp_idx = i;
                break;
            end else begin
                fails  = (ne[w] > MAX_RETRY) ? MAX_RETRY + 1 : ne[w];
                issues = (ne[w] > MAX_RETRY) ? fails : fails + 1;
                for (int a = 0; a < issues; a++) begin
                    exp_q.push_back('{tbl_addr[i], tbl_data[i], pending + FETCH_CYC});
                    pending = 0;
                    err_plan.push_back(a < fails);
                end
                if (ne[w] > MAX_RETRY) begin
                    exp_error = 1'b1;
                    exp_idx   = i;
                    break;
                end
                w++;
            end
        end
        exp_done_gap = pending;
    endtask

    task automatic run_seq(input string tag, input int lat, input int ne0, input int ne1);
        int guard;
        int n;
        build_model(ne0, ne1);
        got_q.delete();
        unstable = 0;
        resp_lat = lat;
        resp_on  = 1'b1;
        do_start();
        guard = 0;
        while (!o_done && !o_error && guard < 3000) begin
            step();
            guard++;
        end
        check({tag, "_terminates"}, 32'(guard < 3000), 1);
        check({tag, "_nwrites"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_wr%0d_addr", tag, k), got_q[k].addr, exp_q[k].addr);
            check($sformatf("%s_wr%0d_data", tag, k), got_q[k].data, exp_q[k].data);
            check($sformatf("%s_wr%0d_gap", tag, k), got_q[k].gap, exp_q[k].gap);
        end
        check({tag, "_wr_stable"}, unstable, 0);
        check({tag, "_gpio_low"}, gpio_low, PWR_OFF_CYC);
        check({tag, "_idx"}, o_entry_idx, exp_idx);
        check({tag, "_gpio"}, o_camera_gpio, !exp_error);
        check({tag, "_done"}, o_done, !exp_error);
        check({tag, "_rx_en"}, o_rx_enable, !exp_error);
        check({tag, "_error"}, o_error, exp_error);
        check({tag, "_busy"}, o_busy, 0);
        if (!exp_error) check({tag, "_done_gap"}, low_run - 1, exp_done_gap);
    endtask

    initial begin : main
        int lost;
        int k;
        int guard;
        tbl_addr[0] = 16'h3008; tbl_data[0] = 8'h82;
        tbl_addr[1] = 16'hFFFF; tbl_data[1] = 8'h03;
        tbl_addr[2] = 16'h0100; tbl_data[2] = 8'h01;
        tbl_addr[3] = 16'hFFFE; tbl_data[3] = 8'h00;

        // Reset state
        i_rst = 1'b1;
        repeat (3) step();
        check("rst_wr", {o_wr_addr, o_wr_data}, 0);
        check("rst_flags", {o_camera_gpio, o_wr_req, o_rx_enable, o_busy, o_done, o_error, o_entry_idx}, 0);
        i_rst = 1'b0;
        repeat (3) step();
        check("idle_stays", {o_camera_gpio, o_busy}, 0);

        // Nominal sequence, ack two cycles after each request
        run_seq("nominal", 2, 0, 0);

        // Ack outside WRITE is ignored
        i_wr_ack = 1'b1;
        i_wr_err = 1'b1;
        step();
        check("stray_ack_done", o_done, 1);
        check("stray_ack_idx", o_entry_idx, 3);

        // Stream persistence / watchdog without vsync
`ifdef CAM_WATCHDOG_EN
        k = 1;
        while (o_done && k < 200) begin
            step();
            if (o_done) k++;
        end
        check("wdt_timeout_cycles", k, WDT_CYC);
        check("wdt_restart_busy", o_busy, 1);
        check("wdt_restart_gpio", o_camera_gpio, 0);
`else
        lost = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!o_done) lost++;
        end
        check("stream_hold_novsync", lost, 0);
`endif

        // Stream held with a vsync edge every 40 cycles
        run_seq("vsync_run", 2, 0, 0);
        lost = 0;
        for (int i = 0; i < 200; i++) begin
            i_frame_vsync = (i % 40 == 0);
            step();
            if (!o_done) lost++;
        end
        i_frame_vsync = 1'b0;
        check("stream_hold_vsync", lost, 0);

        // Retries: two errors then success, and four errors to ERROR
        run_seq("retry2", 2, 2, 0);
        run_seq("retry_fail", 2, 4, 0);

        // Randomized ack latency and error counts
        for (int r = 0; r < 8; r++) begin
            run_seq($sformatf("rand%0d", r), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 4));
        end

        // Restart while the second write is pending
        build_model(0, 0);
        got_q.delete();
        resp_lat = 2;
        resp_on  = 1'b1;
        do_start();
        guard = 0;
        while (got_q.size() < 2 && guard < 500) begin
            step();
            guard++;
        end
        resp_on = 1'b0;
        step();
        check("midwr_req_high", o_wr_req, 1);
        check("midwr_idx_before", o_entry_idx, 2);
        do_start();
        check("midwr_req_drop", o_wr_req, 0);
        check("midwr_idx_clear", o_entry_idx, 0);
        check("midwr_gpio", o_camera_gpio, 0);
        check("midwr_busy", o_busy, 1);
        build_model(0, 0);
        resp_on = 1'b1;
        guard = 0;
        while (!o_done && guard < 500) begin
            step();
            guard++;
        end
        check("midwr_gpio_low", gpio_low, PWR_OFF_CYC);
        check("midwr_completes", o_done, 1);

        // Reset together with start in the middle of DELAY
        build_model(0, 0);
        got_q.delete();
        resp_lat = 2;
        resp_on  = 1'b1;
        do_start();
        guard = 0;
        while (!(got_q.size() == 1 && !o_wr_req) && guard < 500) begin
            step();
            guard++;
        end
        repeat (3) step();
        check("dly_busy", o_busy, 1);
        check("dly_idx", o_entry_idx, 1);
        i_rst   = 1'b1;
        i_start = 1'b1;
        step();
        check("rst_dly_wr", {o_wr_addr, o_wr_data}, 0);
        check("rst_dly_flags", {o_camera_gpio, o_wr_req, o_rx_enable, o_busy, o_done, o_error, o_entry_idx}, 0);
        i_rst = 1'b0;
        repeat (5) step();
        check("rst_no_restart", {o_camera_gpio, o_busy, o_wr_req}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
